// File: rtl/mm_operand_streamer.sv
// mm_operand_streamer: walks a strided run of operand-RAM rows and
// streams them to the MXU lanes through a 2-entry skid FIFO.
// Build option: MM_OPERAND_STREAMER_WR_BYPASS_EN forwards a same-cycle
// LSU write to the read row (RAM returns old data on collision).
module mm_operand_streamer #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 8,
  parameter int LANES  = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_start_addr,
  input  logic [ADDR_W-1:0] cmd_stride,
  input  logic [LEN_W-1:0]  cmd_row_len,
  input  logic [LEN_W-1:0]  cmd_col_len,
  input  logic              ram_wr_vld,
  input  logic [ADDR_W-1:0] ram_wr_addr,
  input  logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_vld,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [LANES-1:0]  mxu_vld,
  input  logic              mxu_rdy,
  output logic [DATA_W-1:0] mxu_data,
  output logic              tile_done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] stride;
  logic [LEN_W-1:0]  row_len;
  logic [LEN_W:0]    row_cnt;
  logic [LANES-1:0]  mask;
  logic              cmd_rdy_q;
  logic              done_q;

  logic              inflight;
  logic [1:0]        fifo_cnt;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [DATA_W-1:0] fifo_mem [2];

  logic              cmd_fire;
  logic              pop;
  logic              push;
  logic [2:0]        occ;
  logic              rd_go;
  logic              last_rd;
  logic [DATA_W-1:0] push_data;

  // Lanes 0..col are active; col >= LANES-1 saturates to all lanes.
  function automatic logic [LANES-1:0] lane_mask(
    input logic [LEN_W-1:0] col
  );
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i <= int'(col)) m[i] = 1'b1;
    end
    return m;
  endfunction

  assign cmd_fire = cmd_vld & cmd_rdy_q;
  assign pop      = (|mxu_vld) & mxu_rdy;
  assign push     = inflight;

  // Occupancy seen by the next issue: queued + in flight - leaving now.
  assign occ = {1'b0, fifo_cnt}
             + {2'b00, inflight}
             - {2'b00, pop};

  assign rd_go   = (state == READ) & (occ < 3'd2);
  assign last_rd = rd_go & (row_cnt == {1'b0, row_len});

  assign ram_rd_vld  = rd_go;
  assign ram_rd_addr = addr;
  assign cmd_rdy     = cmd_rdy_q;
  assign tile_done   = done_q;
  assign mxu_vld     = (fifo_cnt != 2'd0) ? mask : '0;
  assign mxu_data    = fifo_mem[rd_ptr];

`ifdef MM_OPERAND_STREAMER_WR_BYPASS_EN
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;

  // Capture a write that collides with the read issued this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit  <= rd_go & ram_wr_vld
                & (ram_wr_addr == addr);
      byp_data <= ram_wr_data;
    end
  end

  assign push_data = byp_hit ? byp_data : ram_rd_data;
`else
  logic unused_wr;

  assign unused_wr = ^{ram_wr_vld, ram_wr_addr, ram_wr_data};
  assign push_data = ram_rd_data;
`endif

  // Tile sequencer: latch command, walk rows, wait for drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_rdy_q <= 1'b1;
      done_q    <= 1'b0;
      addr      <= '0;
      stride    <= '0;
      row_len   <= '0;
      row_cnt   <= '0;
      mask      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            addr      <= cmd_start_addr;
            stride    <= cmd_stride;
            row_len   <= cmd_row_len;
            row_cnt   <= '0;
            mask      <= lane_mask(cmd_col_len);
            cmd_rdy_q <= 1'b0;
            state     <= READ;
          end
        end
        READ: begin
          if (rd_go) begin
            addr    <= addr + stride;
            row_cnt <= row_cnt
                     + {{LEN_W{1'b0}}, 1'b1};
            if (last_rd) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (occ == 3'd0) begin
            done_q    <= 1'b1;
            cmd_rdy_q <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  // Track the read whose data returns next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= rd_go;
  end

  // Two-entry skid FIFO between RAM return and MXU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt
                + {1'b0, push}
                - {1'b0, pop};
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && (fifo_cnt == 2'd2))
  );

endmodule

// File: tb/tb_mm_operand_streamer.sv
// tb_mm_operand_streamer: random + directed tiles against a
// transaction-level model of the streamer.
module tb_mm_operand_streamer;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 8;
  localparam int LANES  = 16;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_vld = 1'b0;
  logic              cmd_rdy;
  logic [ADDR_W-1:0] cmd_start_addr = '0;
  logic [ADDR_W-1:0] cmd_stride = '0;
  logic [LEN_W-1:0]  cmd_row_len = '0;
  logic [LEN_W-1:0]  cmd_col_len = '0;
  logic              ram_wr_vld = 1'b0;
  logic [ADDR_W-1:0] ram_wr_addr = '0;
  logic [DATA_W-1:0] ram_wr_data = '0;
  logic              ram_rd_vld;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [LANES-1:0]  mxu_vld;
  logic              mxu_rdy = 1'b1;
  logic [DATA_W-1:0] mxu_data;
  logic              tile_done;

  mm_operand_streamer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .LANES(LANES), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_start_addr(cmd_start_addr),
    .cmd_stride(cmd_stride),
    .cmd_row_len(cmd_row_len),
    .cmd_col_len(cmd_col_len),
    .ram_wr_vld(ram_wr_vld),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_vld(ram_rd_vld),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .mxu_vld(mxu_vld), .mxu_rdy(mxu_rdy),
    .mxu_data(mxu_data),
    .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Operand RAM: registered read returning pre-write contents.
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_rd_vld) ram_rd_data <= mem[ram_rd_addr];
    else ram_rd_data <= {$urandom, $urandom, $urandom, $urandom};
    if (ram_wr_vld) mem[ram_wr_addr] <= ram_wr_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [LANES-1:0] exp_mask(input int col);
    if (col >= LANES - 1) return '1;
    return LANES'((32'd1 << (col + 1)) - 1);
  endfunction

  // Reference model state
  int                q_addr [$];
  logic [DATA_W-1:0] q_data [$];
  logic [LANES-1:0]  q_mask [$];
  logic [LANES-1:0]  cur_mask;
  logic [DATA_W-1:0] last_beat;
  int outs = 0, rd_prev = 0, active = 0, done_due = 0;
  int tile_rows = 0, nbeats = 0, max_occ = 0;
  int hs_cnt = 0, done_cnt = 0, hs_on_done = 0;
  int t_hs = 0, t_rd1 = -1, t_b1 = 0, t_bl = 0, t_done = 0;
  int m_p, m_r, m_occ;
  logic [DATA_W-1:0] m_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_addr.delete(); q_data.delete(); q_mask.delete();
      outs = 0; rd_prev = 0; active = 0; done_due = 0;
    end else begin
      m_occ = outs - rd_prev;
      if (m_occ > max_occ) max_occ = m_occ;
      m_p = ((|mxu_vld) && mxu_rdy && m_occ > 0) ? 1 : 0;
      chk("tile_done", tile_done, done_due != 0);
      if (tile_done && active != 0) begin
        active = 0; t_done = cyc; done_cnt++;
        chk("beats", nbeats, tile_rows);
      end
      done_due = 0;
      chk("cmd_rdy", cmd_rdy, active == 0);
      if (m_occ > 0) begin
        chk("mxu_vld", mxu_vld, q_mask[0]);
        chk("mxu_data", mxu_data, q_data[0]);
      end else begin
        chk("mxu_vld", mxu_vld, 0);
      end
      chk("rd_vld", ram_rd_vld,
          q_addr.size() > 0 && (outs - m_p) < 2);
      m_r = 0;
      if (ram_rd_vld && q_addr.size() > 0) begin
        m_r = 1;
        chk("rd_addr", ram_rd_addr, q_addr[0]);
        m_d = mem[q_addr[0]];
`ifdef MM_OPERAND_STREAMER_WR_BYPASS_EN
        if (ram_wr_vld && int'(ram_wr_addr) == q_addr[0])
          m_d = ram_wr_data;
`endif
        q_data.push_back(m_d);
        q_mask.push_back(cur_mask);
        void'(q_addr.pop_front());
        if (t_rd1 < 0) t_rd1 = cyc;
      end
      if (m_p != 0) begin
        last_beat = q_data.pop_front();
        void'(q_mask.pop_front());
        nbeats++;
        if (nbeats == 1) t_b1 = cyc;
        t_bl = cyc;
      end
      outs = outs + m_r - m_p;
      rd_prev = m_r;
      if (active != 0 && m_p != 0 && q_addr.size() == 0
          && outs == 0) done_due = 1;
      if (cmd_vld && cmd_rdy && active == 0) begin
        active = 1; t_hs = cyc; t_rd1 = -1; nbeats = 0;
        tile_rows = int'(cmd_row_len) + 1;
        hs_on_done = tile_done ? 1 : 0;
        cur_mask = exp_mask(int'(cmd_col_len));
        for (int i = 0; i < tile_rows; i++)
          q_addr.push_back((int'(cmd_start_addr)
                            + i * int'(cmd_stride)) & 255);
        hs_cnt++;
      end
    end
  end

  int done_base = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int a, input int s,
                      input int rl, input int cl);
    int h0;
    h0 = hs_cnt;
    done_base = done_cnt;
    cmd_start_addr = ADDR_W'(a);
    cmd_stride = ADDR_W'(s);
    cmd_row_len = LEN_W'(rl);
    cmd_col_len = LEN_W'(cl);
    cmd_vld = 1'b1;
    for (int i = 0; i < 50 && hs_cnt == h0; i++) tick();
    cmd_vld = 1'b0;
    chk("hs_timeout", hs_cnt != h0, 1);
  endtask

  task automatic wait_done(input int rnd);
    int n;
    n = 0;
    while (done_cnt == done_base && n < 500) begin
      if (rnd != 0) begin
        mxu_rdy = 1'($urandom_range(0, 1));
        ram_wr_vld = ($urandom_range(0, 3) == 0);
        ram_wr_addr = ADDR_W'($urandom_range(0, 255));
        ram_wr_data = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      n++;
    end
    ram_wr_vld = 1'b0;
    mxu_rdy = 1'b1;
    chk("done_timeout", done_cnt != done_base, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_rdy"}, cmd_rdy, 1);
    chk({tag, "_rd_vld"}, ram_rd_vld, 0);
    chk({tag, "_rd_addr"}, ram_rd_addr, 0);
    chk({tag, "_mxu_vld"}, mxu_vld, 0);
    chk({tag, "_mxu_data"}, mxu_data, 0);
    chk({tag, "_done"}, tile_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] stale, byp;
    int h0, n, d0;
    for (int i = 0; i < 256; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom};

    tick();
    chk_reset_outs("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Basic tile and its cycle timing
    send(16, 1, 3, 15);
    wait_done(0);
    chk("t_rd1", t_rd1 - t_hs, 1);
    chk("t_beat1", t_b1 - t_hs, 3);
    chk("t_beatN", t_bl - t_hs, 6);
    chk("t_done", t_done - t_hs, 7);
    tick();

    // Stride wrap and partial lane mask
    send(254, 3, 2, 4);
    wait_done(0);
    tick();

    // Backpressure: toggle, then hold low for 5 cycles
    max_occ = 0;
    mxu_rdy = 1'b0;
    send(48, 1, 7, 15);
    for (int i = 0; i < 40; i++) begin
      mxu_rdy = (i >= 4 && i < 9) ? 1'b0 : 1'(i % 2);
      tick();
    end
    wait_done(0);
    chk("max_occ", max_occ, 2);
    tick();

    // Command held valid while busy
    cmd_start_addr = 8'h40;
    cmd_stride = 8'h02;
    cmd_row_len = 4'd3;
    cmd_col_len = 4'd7;
    h0 = hs_cnt;
    cmd_vld = 1'b1;
    n = 0;
    while (hs_cnt < h0 + 2 && n < 100) begin
      tick();
      n++;
    end
    cmd_vld = 1'b0;
    chk("busy_hs", hs_cnt - h0, 2);
    chk("hs_on_done", hs_on_done, 1);
    done_base = done_cnt;
    wait_done(0);
    chk("rd_after_hs", t_rd1 - t_hs, 1);
    tick();

    // Reset during beat 2 of 8
    send(128, 1, 7, 15);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_outs("midrst");
    d0 = done_cnt;
    repeat (20) tick();
    chk("no_done", done_cnt - d0, 0);
    send(96, 5, 3, 9);
    wait_done(0);
    tick();

    // Same-cycle write to the row being read
    stale = {4{32'h1234_5678}};
    byp = {16{8'hA5}};
    mem[32] = stale;
    send(32, 1, 0, 15);
    ram_wr_vld = 1'b1;
    ram_wr_addr = 8'h20;
    ram_wr_data = byp;
    tick();
    ram_wr_vld = 1'b0;
    wait_done(0);
`ifdef MM_OPERAND_STREAMER_WR_BYPASS_EN
    chk("bypass_beat", last_beat, byp);
`else
    chk("bypass_beat", last_beat, stale);
`endif
    tick();

    // Random tiles with random backpressure and writes
    for (int t = 0; t < 25; t++) begin
      send(int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)));
      wait_done(1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_operand_streamer.md
# mm_operand_streamer

Parametrised successor to the matrix-multiply control buffer. It accepts a tile command through a valid/ready handshake and walks a strided run of operand-RAM rows. It returns the read data through a 2-entry skid FIFO to the MXU input lanes with a per-lane valid mask, honouring MXU backpressure. It sits between the LSU operand RAM and the MXU in the LSU matrix path.

## Interface
Parameters:
- DATA_W, 128: RAM row / MXU data width in bits.
- ADDR_W, 8: RAM address width.
- LANES, 16: MXU lane count; width of the lane mask.
- LEN_W, 4: width of the row_len and col_len fields.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_vld  in  1  tile command valid.
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy.
- cmd_start_addr  in  ADDR_W  first row address.
- cmd_stride  in  ADDR_W  address increment per row.
- cmd_row_len  in  LEN_W  row count minus 1.
- cmd_col_len  in  LEN_W  active lane count minus 1; values ≥ LANES saturate to all lanes.
- ram_wr_vld  in  1  LSU write into the operand RAM (snooped).
- ram_wr_addr  in  ADDR_W  write address.
- ram_wr_data  in  DATA_W  write data.
- ram_rd_vld  out  1  RAM read strobe.
- ram_rd_addr  out  ADDR_W  RAM read address.
- ram_rd_data  in  DATA_W  read data, valid exactly 1 cycle after ram_rd_vld.
- mxu_vld  out  LANES  per-lane valid; all-zero means no beat.
- mxu_rdy  in  1  MXU accepts the beat when any mxu_vld bit & mxu_rdy.
- mxu_data  out  DATA_W  beat data.
- tile_done  out  1  single-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, READ, DRAIN.
  - IDLE: cmd_rdy=1. A handshake latches addr, stride, row_len and col_len, clears row_cnt, and goes to READ.
  - READ: issues reads. After the read with row_cnt==row_len, goes to DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is in flight, then pulses tile_done and returns to IDLE.
- Read issue in READ: ram_rd_vld=1 when fifo_cnt + inflight − pop < 2.
  - pop = (mxu_vld≠0) & mxu_rdy.
  - inflight = the read issued in the previous cycle.
- On each issued read:
  - ram_rd_addr = base + row_cnt·stride, truncated mod 2^ADDR_W; wraps silently.
  - Implementation: a running address register adds stride per read. No multiplier.
  - row_cnt increments; it is LEN_W+1 bits wide, so row_len=all-ones does not overflow.
- The returned ram_rd_data is pushed into a 2-entry FIFO the cycle after the read. Push and pop in the same cycle is legal, and the count is unchanged.
- mxu_data = FIFO head.
- mxu_vld = lane mask with bits [min(col_len,LANES−1):0] set, gated by FIFO non-empty. The mask is latched per command.
- The FIFO never overflows by construction; push when full is an assertion error.
- A cmd_vld seen while not in IDLE is ignored; cmd_rdy=0.
- Reset mid-tile: the FSM returns to IDLE and the FIFO and inflight are cleared. No tile_done pulse. Any RAM data returning the cycle after reset is dropped.

## Timing
- Reset values: cmd_rdy=1, ram_rd_vld=0, ram_rd_addr=0, mxu_vld=0, mxu_data=0, tile_done=0.
- Command handshake in cycle 0: first ram_rd_vld in cycle 1, first mxu_vld in cycle 3.
- With mxu_rdy held high, throughput is 1 beat/cycle; R = row_len+1 rows give beats in cycles 3..R+2.
- tile_done: 1 cycle after the cycle in which the last beat is accepted. cmd_rdy rises in the same cycle as tile_done.
- With mxu_rdy low, the FIFO fills to 2 and reads stop. When mxu_rdy rises, a read is issued in that same cycle.

## Configuration
- Macro MM_OPERAND_STREAMER_WR_BYPASS_EN.
- Defined: if ram_wr_vld=1 and ram_wr_addr==ram_rd_addr in the same cycle as ram_rd_vld, the pushed data is ram_wr_data (registered) instead of ram_rd_data. This is read-after-write forwarding for a RAM that returns old data.
- Undefined: ram_wr_* are unused and ram_rd_data is always pushed.

## Test plan
- Basic tile: start=0x10, stride=1, row_len=3, col_len=15, mxu_rdy=1 → reads 0x10..0x13 in cycles 1–4; mxu_vld=0xFFFF in cycles 3–6 carrying the RAM contents in order; tile_done in cycle 7.
- Stride/wrap/mask: start=0xFE, stride=3, row_len=2, col_len=4 → read addresses 0xFE, 0x01, 0x04; mxu_vld=0x001F on each beat.
- Backpressure: row_len=7, with mxu_rdy toggled 0/1 per cycle and held low for 5 cycles → exactly 8 beats, in order, no loss or duplication; ram_rd_vld stops when the FIFO reaches 2.
- Command while busy: cmd_vld held through the tile → cmd_rdy=0 until tile_done; the second command is accepted in the tile_done cycle and its first read follows 1 cycle later.
- Reset mid-tile: rst_n=0 for 1 cycle during beat 2 of 8 → all outputs at reset values the next cycle; no tile_done; a fresh command then runs cleanly.
- Bypass (macro on): write 0xA5.. to 0x20 in the same cycle as a read of 0x20, with the RAM returning stale data → the beat carries 0xA5..; with the macro off, the beat carries the stale value.
